// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg
// Definitions shared by the Model 100 LCD bus reader and write engine:
//   - LCD_NUM_CHIPS : number of controllers on the shared bus
//   - LCD_DI_STATUS / LCD_DI_DATA : values of the di pin for status and data cycles
//   - lcd_rd_state_e : reader state machine encoding
//   - lcd_chip_in_range() : true when a controller index addresses a real chip
package lcd_bus_pkg;

  localparam int   LCD_NUM_CHIPS = 10;
  localparam logic LCD_DI_STATUS = 1'b0;
  localparam logic LCD_DI_DATA   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } lcd_rd_state_e;

  function automatic logic lcd_chip_in_range(input logic [3:0] chip);
    return chip < 4'(LCD_NUM_CHIPS);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer
// Loadable 8-bit down-counter used to time the SETUP, STROBE and HOLD phases.
// The caller loads N-1 on entry to a phase; done is high while the count is 0,
// which marks the last cycle of an N-cycle phase.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val this cycle (takes priority over counting)
//   load_val     : phase length minus one
//   done         : count has reached zero
module lcd_phase_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != 8'd0) begin
      count_reg <= count_reg - 8'd1;
    end
  end

  assign done = (count_reg == 8'd0);

endmodule

// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader
// Read-side initiator for the Model 100 LCD controller bus. Accepts one read
// request at a time, borrows the cs/rw/di/enable pins from the write engine via
// bus_req/bus_gnt, runs SETUP/STROBE/HOLD and returns the byte seen on data_in
// on the last strobe cycle. The data pads are never driven (data_oe = 0).
// Optional build macro: LCD_READ_DUMMY_EN -- data reads run the full cycle
// twice under one grant and return only the second sample.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   req_valid/req_ready/req_chip/req_di : request handshake (ready only in IDLE)
//   rsp_valid/rsp_data/rsp_err    : one-cycle response pulse, data/err held after
//   bus_req/bus_gnt               : pin arbitration with the write engine
//   data_in/data_oe               : LCD data pads (input only)
//   cs_pin/cs1_pin/rw_pin/di_pin/enable_pin : LCD control pins
module lcd_bus_reader
  import lcd_bus_pkg::*;
#(
  parameter int unsigned T_AS = 4,
  parameter int unsigned T_EW = 24,
  parameter int unsigned T_AH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_chip,
  input  logic                     req_di,
  output logic                     rsp_valid,
  output logic [7:0]               rsp_data,
  output logic                     rsp_err,
  output logic                     bus_req,
  input  logic                     bus_gnt,
  input  logic [7:0]               data_in,
  output logic                     data_oe,
  output logic [LCD_NUM_CHIPS-1:0] cs_pin,
  output logic                     cs1_pin,
  output logic                     rw_pin,
  output logic                     di_pin,
  output logic                     enable_pin
);

  localparam logic [7:0] AS_LOAD = 8'(T_AS - 1);
  localparam logic [7:0] EW_LOAD = 8'(T_EW - 1);
  localparam logic [7:0] AH_LOAD = 8'(T_AH - 1);

  lcd_rd_state_e state_reg, state_next;
  logic [3:0]    chip_reg, chip_next;
  logic          di_reg, di_next;
  logic          err_reg, err_next;
  logic          pass_reg, pass_next;   // set during the second (real) pass
  logic [7:0]    sample_reg, sample_next;

  logic          timer_load;
  logic [7:0]    timer_val;
  logic          timer_done;

  // Output flops; pin values are decoded from the next state so every output
  // changes on the same edge as the state it belongs to.
  logic                     req_ready_reg, rsp_valid_reg, rsp_err_reg, bus_req_reg;
  logic [7:0]               rsp_data_reg;
  logic [LCD_NUM_CHIPS-1:0] cs_reg, cs_next;
  logic                     cs1_reg, rw_reg, di_pin_reg, enable_reg;
  logic                     pins_active_next;

  lcd_phase_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    state_next  = state_reg;
    chip_next   = chip_reg;
    di_next     = di_reg;
    err_next    = err_reg;
    pass_next   = pass_reg;
    sample_next = sample_reg;
    timer_load  = 1'b0;
    timer_val   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          chip_next = req_chip;
          di_next   = req_di;
          pass_next = 1'b0;
          if (lcd_chip_in_range(req_chip)) begin
            err_next   = 1'b0;
            state_next = ST_ARB;
          end else begin
            // Bad index: answer immediately without touching the bus.
            err_next   = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_ARB: begin
        if (bus_gnt) begin
          state_next = ST_SETUP;
          timer_load = 1'b1;
          timer_val  = AS_LOAD;
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          state_next = ST_STROBE;
          timer_load = 1'b1;
          timer_val  = EW_LOAD;
        end
      end
      ST_STROBE: begin
        if (timer_done) begin
          sample_next = data_in;
          state_next  = ST_HOLD;
          timer_load  = 1'b1;
          timer_val   = AH_LOAD;
        end
      end
      ST_HOLD: begin
        if (timer_done) begin
`ifdef LCD_READ_DUMMY_EN
          // Data reads need a throw-away strobe first; repeat under the same grant.
          if (di_reg == LCD_DI_DATA && !pass_reg) begin
            pass_next  = 1'b1;
            state_next = ST_SETUP;
            timer_load = 1'b1;
            timer_val  = AS_LOAD;
          end else begin
            state_next = ST_DONE;
          end
`else
          state_next = ST_DONE;
`endif
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pins_active_next = (state_next == ST_SETUP) || (state_next == ST_STROBE) ||
                       (state_next == ST_HOLD);
  end

  generate
    for (genvar gi = 0; gi < LCD_NUM_CHIPS; gi++) begin : g_cs
      assign cs_next[gi] = pins_active_next && (chip_next == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      chip_reg      <= '0;
      di_reg        <= 1'b0;
      err_reg       <= 1'b0;
      pass_reg      <= 1'b0;
      sample_reg    <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      bus_req_reg   <= 1'b0;
      cs_reg        <= '0;
      cs1_reg       <= 1'b0;
      rw_reg        <= 1'b0;
      di_pin_reg    <= 1'b0;
      enable_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      chip_reg      <= chip_next;
      di_reg        <= di_next;
      err_reg       <= err_next;
      pass_reg      <= pass_next;
      sample_reg    <= sample_next;
      req_ready_reg <= (state_next == ST_IDLE);
      rsp_valid_reg <= (state_next == ST_DONE);
      // Response fields only move together with rsp_valid.
      if (state_next == ST_DONE) begin
        rsp_data_reg <= err_next ? 8'h00 : sample_next;
        rsp_err_reg  <= err_next;
      end
      bus_req_reg   <= (state_next == ST_ARB) || pins_active_next;
      cs_reg        <= cs_next;
      cs1_reg       <= pins_active_next;
      rw_reg        <= pins_active_next;
      di_pin_reg    <= pins_active_next && di_next;
      enable_reg    <= (state_next == ST_STROBE);
    end
  end

  assign req_ready  = req_ready_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_err    = rsp_err_reg;
  assign bus_req    = bus_req_reg;
  assign data_oe    = 1'b0;
  assign cs_pin     = cs_reg;
  assign cs1_pin    = cs1_reg;
  assign rw_pin     = rw_reg;
  assign di_pin     = di_pin_reg;
  assign enable_pin = enable_reg;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader. Cycle 0 is the cycle whose rising
// edge accepts a request; outputs are sampled and inputs driven on the falling
// edge. Expected latency/data come from the bus timing rules directly.
module tb_lcd_bus_reader;

  localparam int T_AS = 4;
  localparam int T_EW = 24;
  localparam int T_AH = 4;
`ifdef LCD_READ_DUMMY_EN
  localparam bit DUMMY = 1'b1;
`else
  localparam bit DUMMY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_chip;
  logic       req_di;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       bus_req;
  logic       bus_gnt;
  logic [7:0] data_in;
  logic       data_oe;
  logic [9:0] cs_pin;
  logic       cs1_pin;
  logic       rw_pin;
  logic       di_pin;
  logic       enable_pin;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lcd_bus_reader #(.T_AS(T_AS), .T_EW(T_EW), .T_AH(T_AH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_chip(req_chip), .req_di(req_di),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .data_in(data_in), .data_oe(data_oe),
    .cs_pin(cs_pin), .cs1_pin(cs1_pin), .rw_pin(rw_pin), .di_pin(di_pin),
    .enable_pin(enable_pin)
  );

  // One complete read. gdly = cycles of bus_gnt low in ARB; drop = release
  // bus_gnt once SETUP has started (must be ignored). data_in is d0 until five
  // cycles before enable falls on the final strobe, then d1.
  task automatic do_read(input logic [3:0] chip, input logic di, input int gdly,
                         input bit drop, input logic [7:0] d0, input logic [7:0] d1,
                         input string name);
    int passes, per, lat, s_end, en_cnt, bad_pin, k, k_seen;
    bit in_rng, seen;
    logic [9:0] cs_exp;
    logic [7:0] exp_data;
    in_rng   = (chip < 4'd10);
    passes   = (DUMMY && di) ? 2 : 1;
    per      = T_AS + T_EW + T_AH;
    lat      = in_rng ? 2 + gdly + passes * per : 1;
    s_end    = 2 + gdly + (passes - 1) * per + T_AS + T_EW - 1;
    cs_exp   = '0;
    if (in_rng) cs_exp[chip] = 1'b1;
    exp_data = in_rng ? d1 : 8'h00;
    en_cnt = 0; bad_pin = 0; seen = 0; k_seen = -1;

    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_before: got %b expected 1", name, req_ready);
    end
    req_valid = 1'b1; req_chip = chip; req_di = di;
    bus_gnt = (gdly == 0); data_in = d0;

    k = 1;
    while (!seen && k <= lat + 50) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (enable_pin === 1'b1) begin
        en_cnt++;
        if (cs_pin !== cs_exp || cs1_pin !== 1'b1 || rw_pin !== 1'b1 || di_pin !== di) bad_pin++;
      end else if (k <= gdly + 1 &&
                   (cs_pin !== '0 || cs1_pin !== 1'b0 || rw_pin !== 1'b0 || di_pin !== 1'b0)) begin
        bad_pin++;
      end
      if (data_oe !== 1'b0) bad_pin++;
      if (in_rng && k < lat && bus_req !== 1'b1) bad_pin++;
      if (!in_rng && (bus_req !== 1'b0 || cs_pin !== '0 || cs1_pin !== 1'b0)) bad_pin++;
      if (rsp_valid === 1'b1) begin
        seen = 1; k_seen = k;
        tests_run++;
        if (rsp_data !== exp_data) begin
          tests_failed++;
          $display("FAIL %s rsp_data: got %02h expected %02h", name, rsp_data, exp_data);
        end
        tests_run++;
        if (rsp_err !== !in_rng) begin
          tests_failed++;
          $display("FAIL %s rsp_err: got %b expected %b", name, rsp_err, !in_rng);
        end
      end
      bus_gnt = (k > gdly) && !(drop && k > gdly + 2);
      data_in = (k >= s_end - 4) ? d1 : d0;
      k++;
    end

    tests_run++;
    if (k_seen != lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d expected %0d", name, k_seen, lat);
    end
    tests_run++;
    if (en_cnt != (in_rng ? passes * T_EW : 0)) begin
      tests_failed++;
      $display("FAIL %s enable_cycles: got %0d expected %0d", name, en_cnt,
               in_rng ? passes * T_EW : 0);
    end
    tests_run++;
    if (bad_pin != 0) begin
      tests_failed++;
      $display("FAIL %s pin_errors: got %0d expected 0", name, bad_pin);
    end

    @(negedge clk);
    bus_gnt = 1'b1;
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== exp_data) begin
      tests_failed++;
      $display("FAIL %s after_rsp: got valid=%b ready=%b data=%02h expected 0 1 %02h",
               name, rsp_valid, req_ready, rsp_data, exp_data);
    end
    $display("[TB] %s chip=%0d di=%0d gdly=%0d lat=%0d data=%02h err=%0b",
             name, chip, di, gdly, k_seen, rsp_data, rsp_err);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_chip = '0; req_di = 1'b0;
    bus_gnt = 1'b1; data_in = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_err !== 1'b0 ||
        bus_req !== 1'b0 || cs_pin !== '0 || cs1_pin !== 1'b0 || rw_pin !== 1'b0 ||
        di_pin !== 1'b0 || enable_pin !== 1'b0 || data_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: got ready=%b valid=%b data=%02h cs=%03h en=%b breq=%b expected 1 0 00 000 0 0",
               req_ready, rsp_valid, rsp_data, cs_pin, enable_pin, bus_req);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || bus_req !== 1'b0 || enable_pin !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got ready=%b breq=%b en=%b expected 1 0 0",
               req_ready, bus_req, enable_pin);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_status_read();
    do_read(4'd3, 1'b0, 0, 1'b0, 8'h80, 8'h80, "status_chip3");
  endtask

  task automatic test_data_read();
    do_read(4'd9, 1'b1, 0, 1'b0, 8'h11, 8'h5A, "data_chip9");
  endtask

  task automatic test_bad_chip();
    do_read(4'd12, 1'b0, 0, 1'b0, 8'hFF, 8'hFF, "bad_chip12");
    do_read(4'd10, 1'b1, 0, 1'b0, 8'hC3, 8'hC3, "bad_chip10");
  endtask

  task automatic test_gnt_delay();
    do_read(4'd0, 1'b0, 10, 1'b0, 8'h3C, 8'hA7, "gnt_delay10");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      do_read(4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid();
    int n, cnt;
    @(negedge clk);
    req_valid = 1'b1; req_chip = 4'd5; req_di = 1'b0; bus_gnt = 1'b1; data_in = 8'h77;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (enable_pin !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (enable_pin !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid strobe_reached: got en=%b expected 1", enable_pin);
    end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (enable_pin !== 1'b0 || cs_pin !== '0 || bus_req !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid async: got en=%b cs=%03h breq=%b ready=%b expected 0 000 0 1",
               enable_pin, cs_pin, bus_req, req_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || enable_pin === 1'b1) cnt++;
    end
    tests_run++;
    if (cnt != 0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid no_response: got activity=%0d ready=%b expected 0 1", cnt, req_ready);
    end
    $display("[TB] reset_mid done");
  endtask

  task automatic test_back_to_back();
    int acc, rsp, bad, lat;
    int acc_cyc[2];
    int rsp_cyc[2];
    bit drop;
    lat = 2 + T_AS + T_EW + T_AH;
    acc = 0; rsp = 0; bad = 0; drop = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1; rsp_cyc[0] = -1; rsp_cyc[1] = -1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b ready0: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; req_chip = 4'd2; req_di = 1'b0; bus_gnt = 1'b1; data_in = 8'h42;
    acc_cyc[0] = 0; acc = 1;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      if (k == 1) req_chip = 4'd7;
      if (drop) req_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        if (rsp < 2) rsp_cyc[rsp] = k;
        rsp++;
      end
      if (enable_pin === 1'b1 && acc == 2 && cs_pin !== 10'h080) bad++;
      if (req_valid === 1'b1 && req_ready === 1'b1) begin
        if (acc < 2) acc_cyc[acc] = k;
        acc++;
        drop = 1;
      end
    end
    tests_run++;
    if (rsp != 2) begin
      tests_failed++;
      $display("FAIL b2b response_count: got %0d expected 2", rsp);
    end
    tests_run++;
    if (rsp_cyc[0] != lat) begin
      tests_failed++;
      $display("FAIL b2b first_rsp: got %0d expected %0d", rsp_cyc[0], lat);
    end
    tests_run++;
    if (acc_cyc[1] != lat + 1) begin
      tests_failed++;
      $display("FAIL b2b second_accept: got %0d expected %0d", acc_cyc[1], lat + 1);
    end
    tests_run++;
    if (rsp_cyc[1] != 2 * lat + 1) begin
      tests_failed++;
      $display("FAIL b2b second_rsp: got %0d expected %0d", rsp_cyc[1], 2 * lat + 1);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL b2b second_cs: got %0d bad cycles expected 0", bad);
    end
    $display("[TB] back_to_back accepts=%0d,%0d rsps=%0d,%0d",
             acc_cyc[0], acc_cyc[1], rsp_cyc[0], rsp_cyc[1]);
  endtask

  initial begin
    test_reset();
    test_status_read();
    test_data_read();
    test_bad_chip();
    test_gnt_delay();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lcd_bus_reader.md
# lcd_bus_reader

Read-side initiator for the Model 100 LCD controller bus: performs status and display-data read cycles on the shared 10-chip, 8-bit LCD bus and returns the byte sampled from the selected controller. Sits beside the existing LCD write engine, shares the same cs/rw/di/enable pins through a request/grant arbitration handshake, and never drives the data bus.

## Interface
- T_AS, 4: address setup cycles (cs/rw/di stable before enable rises), 1..255
- T_EW, 24: enable-high cycles (500 ns at 48 MHz), 1..255
- T_AH, 4: hold cycles after enable falls, 1..255

- clk  in  1  system clock (48 MHz HFOSC)
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  read request
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_chip  in  4  controller index 0..9
- req_di  in  1  0 = status read, 1 = display-data read
- rsp_valid  out  1  one-cycle pulse, no backpressure
- rsp_data  out  8  sampled byte; holds until next rsp_valid
- rsp_err  out  1  qualifies rsp_valid; 1 = req_chip out of range
- bus_req  out  1  request LCD pins from write engine
- bus_gnt  in  1  write engine has released pins
- data_in  in  8  LCD data pads (input only)
- data_oe  out  1  pad drive enable; constant 0
- cs_pin  out  10  one-hot active-high chip select
- cs1_pin  out  1  high while reader owns the bus
- rw_pin  out  1  1 during reader cycles
- di_pin  out  1  req_di registered at acceptance
- enable_pin  out  1  read strobe

## Operation
- States: IDLE, ARB, SETUP, STROBE, HOLD, DONE.
- IDLE: req_ready=1. On accept, register chip/di. Chip >= 10 -> DONE with rsp_err=1, rsp_data=0, no bus activity. Otherwise -> ARB.
- ARB: bus_req=1; pins still idle. bus_gnt sampled 1 -> SETUP.
- SETUP: cs_pin[chip]=1, cs1_pin=1, rw_pin=1, di_pin=di, enable_pin=0 for T_AS cycles -> STROBE.
- STROBE: enable_pin=1 for T_EW cycles; data_in registered into rsp_data on the last STROBE cycle -> HOLD.
- HOLD: enable_pin=0, cs/rw/di unchanged, for T_AH cycles -> DONE.
- DONE: rsp_valid=1 one cycle, all pins idle, bus_req=0 -> IDLE.
- Idle pin values: cs_pin=0, cs1_pin=0, rw_pin=0, di_pin=0, enable_pin=0, bus_req=0.
- bus_gnt falling after SETUP is ignored; the write engine holds grant until bus_req falls.
- req_valid while not ready: ignored, no queueing.

## Timing
- All outputs registered; reset values: req_ready=1, everything else 0. Reset asserts asynchronously mid-cycle: enable_pin and cs_pin drop immediately, no response issued.
- Phase counter 8 bits, loads N-1 on phase entry, exits at 0.
- Accept at cycle 0, bus_gnt already high: ARB cycle 1, SETUP 2..T_AS+1, STROBE then HOLD, rsp_valid at cycle 2+T_AS+T_EW+T_AH (34 with defaults).
- Each cycle of bus_gnt low in ARB adds one cycle.
- Out-of-range chip: rsp_valid at cycle 1; req_ready back at cycle 2.
- Back-to-back: next accept earliest the cycle after rsp_valid.

## Configuration
- LCD_READ_DUMMY_EN defined: data reads (req_di=1) run SETUP/STROBE/HOLD twice without releasing bus_req; first sample discarded, second returned; latency 2+2*(T_AS+T_EW+T_AH) (66 default). Status reads unchanged.
- Undefined: single cycle for both read types.

## Structure
- Package lcd_bus_pkg: state enum, LCD_NUM_CHIPS=10, LCD_DI_STATUS=0, LCD_DI_DATA=1; shared with the write engine.
- Sub-module lcd_phase_timer: loadable 8-bit down-counter with done flag, reused for the three phases.

## Test plan
- Status read chip 3, bus_gnt tied 1, data_in=8'h80 -> cs_pin=10'h008, rw=1, di=0, enable high 24 cycles, rsp_data=8'h80, rsp_err=0, rsp_valid at cycle 34.
- Data read chip 9, data_in changes 8'h11->8'h5A five cycles before enable falls -> rsp_data=8'h5A; with LCD_READ_DUMMY_EN two strobes seen, rsp_valid at cycle 66.
- req_chip=12 -> no enable/cs activity, rsp_valid at cycle 1 with rsp_err=1, rsp_data=0.
- bus_gnt held low 10 cycles after accept -> pins idle throughout, rsp_valid at cycle 44.
- reset_n pulsed low during STROBE -> enable_pin and cs_pin 0 same cycle, no rsp_valid, req_ready=1 after release.
- req_valid held through transaction with new chip -> second accept only the cycle after rsp_valid, exactly two responses.
